// File: rtl/qic117_pkg.sv
// -----------------------------------------------------------------------------
// qic117_pkg
// Shared definitions for the QIC-117 step-pulse command path (host-side
// step generator and drive-side step-counter decoder).
//   - legal command code range
//   - named command codes
//   - burst sequencer state enum
//   - small elaboration helpers
// -----------------------------------------------------------------------------
package qic117_pkg;

    localparam int unsigned QIC117_CMD_MIN = 1;
    localparam int unsigned QIC117_CMD_MAX = 48;

    // Command codes: the drive decodes command N from a burst of N STEP pulses.
    localparam logic [5:0] QIC117_SOFT_RESET          = 6'd1;
    localparam logic [5:0] QIC117_REPORT_NEXT_BIT     = 6'd2;
    localparam logic [5:0] QIC117_PAUSE               = 6'd3;
    localparam logic [5:0] QIC117_MICRO_STEP_PAUSE    = 6'd4;
    localparam logic [5:0] QIC117_ALT_CMD_TIMEOUT     = 6'd5;
    localparam logic [5:0] QIC117_REPORT_DRIVE_STATUS = 6'd6;
    localparam logic [5:0] QIC117_REPORT_ERROR_CODE   = 6'd7;
    localparam logic [5:0] QIC117_REPORT_DRIVE_CONFIG = 6'd8;
    localparam logic [5:0] QIC117_REPORT_ROM_VERSION  = 6'd9;
    localparam logic [5:0] QIC117_LOGICAL_FORWARD     = 6'd10;
    localparam logic [5:0] QIC117_PHYSICAL_REVERSE    = 6'd11;
    localparam logic [5:0] QIC117_PHYSICAL_FORWARD    = 6'd12;
    localparam logic [5:0] QIC117_SEEK_HEAD_TO_TRACK  = 6'd13;
    localparam logic [5:0] QIC117_SEEK_LOAD_POINT     = 6'd14;
    localparam logic [5:0] QIC117_ENTER_FORMAT_MODE   = 6'd15;
    localparam logic [5:0] QIC117_WRITE_REF_BURST     = 6'd16;
    localparam logic [5:0] QIC117_ENTER_VERIFY_MODE   = 6'd17;
    localparam logic [5:0] QIC117_STOP_TAPE           = 6'd18;
    localparam logic [5:0] QIC117_MICRO_STEP_UP       = 6'd21;
    localparam logic [5:0] QIC117_MICRO_STEP_DOWN     = 6'd22;
    localparam logic [5:0] QIC117_SOFT_SELECT         = 6'd23;
    localparam logic [5:0] QIC117_SOFT_DESELECT       = 6'd24;
    localparam logic [5:0] QIC117_SKIP_REVERSE        = 6'd25;
    localparam logic [5:0] QIC117_SKIP_FORWARD        = 6'd26;
    localparam logic [5:0] QIC117_SELECT_RATE         = 6'd27;
    localparam logic [5:0] QIC117_ENTER_DIAG_1        = 6'd28;
    localparam logic [5:0] QIC117_ENTER_DIAG_2        = 6'd29;
    localparam logic [5:0] QIC117_ENTER_PRIMARY_MODE  = 6'd30;
    localparam logic [5:0] QIC117_REPORT_VENDOR_ID    = 6'd32;
    localparam logic [5:0] QIC117_REPORT_TAPE_STATUS  = 6'd33;
    localparam logic [5:0] QIC117_SKIP_EXT_REVERSE    = 6'd34;
    localparam logic [5:0] QIC117_SKIP_EXT_FORWARD    = 6'd35;
    localparam logic [5:0] QIC117_CALIBRATE_TAPE_LEN  = 6'd36;
    localparam logic [5:0] QIC117_REPORT_FMT_SEGMENTS = 6'd37;
    localparam logic [5:0] QIC117_SET_FMT_SEGMENTS    = 6'd38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_QUIET,
        ST_DONE
    } qic117_state_t;

    function automatic int unsigned qic117_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic qic117_code_ok(input logic [5:0] code);
        return (code >= 6'(QIC117_CMD_MIN)) && (code <= 6'(QIC117_CMD_MAX));
    endfunction

endpackage

// File: rtl/qic117_interval_timer.sv
// -----------------------------------------------------------------------------
// qic117_interval_timer
// Loadable down-counter with a zero flag. Counts down by one per clock and
// parks at zero. clear has priority over load.
//   clk, reset   clock, asynchronous active-high reset (count -> 0)
//   clear        force count to zero
//   load         load load_value
//   load_value   WIDTH-bit reload value
//   zero         count == 0
// -----------------------------------------------------------------------------
module qic117_interval_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/qic117_step_generator.sv
// -----------------------------------------------------------------------------
// qic117_step_generator
// Host-side QIC-117 command transmitter: turns a 6-bit command code into a
// burst of N STEP pulses followed by a silence long enough for the drive to
// close the command window.
//
// Build option:
//   QIC117_STEPGEN_QUIET_EN  defined  -> post-burst QUIET state compiled in
//                            undefined -> burst ends straight in DONE; caller
//                                         spaces commands itself
//
// Ports:
//   clk           FDC clock
//   reset         asynchronous active-high reset
//   tape_mode_en  generator enable; low aborts and holds idle
//   cmd_code      command code, legal range 1..48
//   cmd_valid     request strobe/hold
//   cmd_ready     command can be accepted this cycle
//   step_out      registered STEP drive, active-high
//   busy          burst (or quiet period) in progress
//   pulses_sent   pulses emitted for the current/last command
//   cmd_done      one-cycle pulse at command completion
//   cmd_error     one-cycle pulse when a code is rejected
//
// Sub-module: qic117_interval_timer (single shared down-counter).
// -----------------------------------------------------------------------------
module qic117_step_generator
    import qic117_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 200_000_000,
    parameter int unsigned PULSE_US    = 20,
    parameter int unsigned PERIOD_US   = 2500,
    parameter int unsigned QUIET_MS    = 110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tape_mode_en,
    input  logic [5:0] cmd_code,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       step_out,
    output logic       busy,
    output logic [5:0] pulses_sent,
    output logic       cmd_done,
    output logic       cmd_error
);

    localparam int unsigned CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PULSE_CLKS  = CLKS_PER_US * PULSE_US;
    localparam int unsigned GAP_CLKS    = CLKS_PER_US * (PERIOD_US - PULSE_US);

`ifdef QIC117_STEPGEN_QUIET_EN
    localparam int unsigned QUIET_CLKS  = (CLK_FREQ_HZ / 1000) * QUIET_MS;
    localparam int unsigned TIMER_MAX   = qic117_max(qic117_max(PULSE_CLKS, GAP_CLKS), QUIET_CLKS);
`else
    localparam int unsigned TIMER_MAX   = qic117_max(PULSE_CLKS, GAP_CLKS);
`endif

    localparam int unsigned TIMER_W = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CLKS - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CLKS - 1);
`ifdef QIC117_STEPGEN_QUIET_EN
    localparam logic [TIMER_W-1:0] QUIET_LOAD = TIMER_W'(QUIET_CLKS - 1);
`endif

    // Timing that cannot produce a legal burst is refused at elaboration.
    if (CLKS_PER_US == 0 || PULSE_US == 0 || PERIOD_US <= PULSE_US || QUIET_MS == 0) begin : g_bad_timing
        $error("qic117_step_generator: illegal timing parameters");
    end

    qic117_state_t    state;
    logic [5:0]       remaining;
    logic             accept;
    logic             code_ok;
    logic             timer_zero;
    logic             timer_load;
    logic [TIMER_W-1:0] timer_value;

    assign cmd_ready = (state == ST_IDLE) && tape_mode_en && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign code_ok   = qic117_code_ok(cmd_code);

    // Reload requests mirror the state transitions below; an abort clears the
    // timer instead so the next command always starts from a clean count.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (accept && code_ok) begin
                    timer_load  = 1'b1;
                    timer_value = PULSE_LOAD;
                end
            end
            ST_HIGH: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = GAP_LOAD;
                end
            end
            ST_LOW: begin
                if (timer_zero) begin
                    if (remaining > 6'd1) begin
                        timer_load  = 1'b1;
                        timer_value = PULSE_LOAD;
                    end else begin
`ifdef QIC117_STEPGEN_QUIET_EN
                        timer_load  = 1'b1;
                        timer_value = QUIET_LOAD;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    qic117_interval_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!tape_mode_en),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Outputs are registered alongside the state, so step_out/busy/cmd_done
    // are set from the state being entered rather than decoded afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            step_out    <= 1'b0;
            busy        <= 1'b0;
            pulses_sent <= '0;
            cmd_done    <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
            if (!tape_mode_en) begin
                state    <= ST_IDLE;
                step_out <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (code_ok) begin
                                remaining   <= cmd_code;
                                pulses_sent <= '0;
                                state       <= ST_HIGH;
                                step_out    <= 1'b1;
                                busy        <= 1'b1;
                            end else begin
                                cmd_error <= 1'b1;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (timer_zero) begin
                            pulses_sent <= pulses_sent + 6'd1;
                            state       <= ST_LOW;
                            step_out    <= 1'b0;
                        end
                    end
                    ST_LOW: begin
                        if (timer_zero) begin
                            if (remaining > 6'd1) begin
                                remaining <= remaining - 6'd1;
                                state     <= ST_HIGH;
                                step_out  <= 1'b1;
                            end else begin
`ifdef QIC117_STEPGEN_QUIET_EN
                                state    <= ST_QUIET;
`else
                                state    <= ST_DONE;
                                cmd_done <= 1'b1;
`endif
                            end
                        end
                    end
                    ST_QUIET: begin
                        if (timer_zero) begin
                            state    <= ST_DONE;
                            cmd_done <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        step_out <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qic117_step_generator.sv
module tb_qic117_step_generator;

    // Scaled timing so whole bursts fit in a short run: 3-cycle pulses,
    // 5-cycle gaps, 1000-cycle quiet period.
    localparam int unsigned CLK_HZ    = 1_000_000;
    localparam int unsigned PULSE_US  = 3;
    localparam int unsigned PERIOD_US = 8;
    localparam int unsigned QUIET_MS  = 1;
    localparam int P   = (CLK_HZ / 1_000_000) * PULSE_US;
    localparam int G   = (CLK_HZ / 1_000_000) * (PERIOD_US - PULSE_US);
    localparam int PER = P + G;
`ifdef QIC117_STEPGEN_QUIET_EN
    localparam int QE  = (CLK_HZ / 1000) * QUIET_MS;
`else
    localparam int QE  = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tape_mode_en = 1'b0;
    logic [5:0] cmd_code = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       step_out;
    logic       busy;
    logic [5:0] pulses_sent;
    logic       cmd_done;
    logic       cmd_error;

    qic117_step_generator #(
        .CLK_FREQ_HZ (CLK_HZ),
        .PULSE_US    (PULSE_US),
        .PERIOD_US   (PERIOD_US),
        .QUIET_MS    (QUIET_MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tape_mode_en (tape_mode_en),
        .cmd_code     (cmd_code),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .step_out     (step_out),
        .busy         (busy),
        .pulses_sent  (pulses_sent),
        .cmd_done     (cmd_done),
        .cmd_error    (cmd_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int done_cnt = 0;
    logic prev_step = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per cycle, outputs follow from the accept cycle and the code by plain
    // arithmetic: cycle k after accept (k=0 is the first STEP-high cycle).
    bit m_active = 0;
    int m_t0 = 0;
    int m_n = 0;
    int m_hold = 0;
    int m_err_due = -1;

    always @(negedge clk) begin
        int k, done_k, q, e_step, e_busy, e_done, e_puls, e_ready, e_err;
        k = 0; done_k = 0;
        if (reset) begin
            e_step = 0; e_busy = 0; e_done = 0; e_puls = 0; e_ready = 0;
            m_active = 0; m_hold = 0; m_err_due = -1;
        end else if (m_active) begin
            k      = cyc - m_t0;
            done_k = m_n * PER + QE;
            e_step = (k < m_n * PER) && ((k % PER) < P) ? 1 : 0;
            e_busy = 1;
            e_done = (k == done_k) ? 1 : 0;
            if (k < P) e_puls = 0;
            else begin
                q = (k - P) / PER + 1;
                e_puls = (q < m_n) ? q : m_n;
            end
            e_ready = 0;
        end else begin
            e_step = 0; e_busy = 0; e_done = 0; e_puls = m_hold;
            e_ready = tape_mode_en ? 1 : 0;
        end
        e_err = (!reset && cyc == m_err_due) ? 1 : 0;

        check("step_out", step_out, e_step);
        check("busy", busy, e_busy);
        check("cmd_done", cmd_done, e_done);
        check("pulses_sent", pulses_sent, e_puls);
        check("cmd_ready", cmd_ready, e_ready);
        check("cmd_error", cmd_error, e_err);

        if (!reset) begin
            if (m_active) begin
                if (!tape_mode_en || k == done_k) begin
                    m_active = 0;
                    m_hold   = e_puls;
                end
            end else if (e_ready != 0 && cmd_valid) begin
                if (cmd_code >= 6'd1 && cmd_code <= 6'd48) begin
                    m_active = 1;
                    m_t0     = cyc + 1;
                    m_n      = cmd_code;
                end else begin
                    m_err_due = cyc + 1;
                end
            end
        end

        if (step_out === 1'b1 && prev_step === 1'b0) rise_cnt++;
        prev_step = step_out;
        if (cmd_done === 1'b1) done_cnt++;
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (cmd_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic [5:0] code;
        bit         exp_err;
        int         exp_pulses;
        int         exp_span;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok;
        int n, r0, d0, limit;
        int code, hold, abort_at;

        vecs[0] = '{6'd3,  1'b0, 3,  3 * PER + QE + 1};
        vecs[1] = '{6'd0,  1'b1, 0,  0};
        vecs[2] = '{6'd49, 1'b1, 0,  0};
        vecs[3] = '{6'd48, 1'b0, 48, 48 * PER + QE + 1};
        vecs[4] = '{6'd1,  1'b0, 1,  PER + QE + 1};
        vecs[5] = '{6'd63, 1'b1, 0,  0};
        vecs[6] = '{6'd2,  1'b0, 2,  2 * PER + QE + 1};
        limit = 48 * PER + QE + 50;

        // Reset state
        repeat (3) tick();
        check("reset_step", step_out, 0);
        check("reset_ready", cmd_ready, 0);
        check("reset_pulses", pulses_sent, 0);
        reset = 1'b0;
        tape_mode_en = 1'b1;
        tick();

        // Directed table
        foreach (vecs[i]) begin
            wait_ready(ok);
            check("ready_before_cmd", ok, 1);
            cmd_code  = vecs[i].code;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            cmd_code  = 6'($urandom);
            if (vecs[i].exp_err) begin
                check("error_pulse", cmd_error, 1);
                r0 = rise_cnt;
                repeat (20) tick();
                check("no_step_on_reject", rise_cnt - r0, 0);
                check("ready_after_reject", cmd_ready, 1);
            end else begin
                r0 = rise_cnt;
                wait_done(limit, n);
                check("burst_span", n, vecs[i].exp_span);
                check("final_pulses", pulses_sent, vecs[i].exp_pulses);
                tick();
                check("rising_edges", rise_cnt - r0, vecs[i].exp_pulses);
                check("ready_after_done", cmd_ready, 1);
                check("pulses_hold_idle", pulses_sent, vecs[i].exp_pulses);
            end
        end

        // Abort one cycle into pulse 2
        wait_ready(ok);
        d0 = done_cnt;
        cmd_code = 6'd4; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (PER + 1) tick();
        check("abort_pre_step", step_out, 1);
        tape_mode_en = 1'b0;
        tick();
        check("abort_step", step_out, 0);
        check("abort_busy", busy, 0);
        check("abort_pulses", pulses_sent, 1);
        repeat (4 * PER + QE + 10) tick();
        check("abort_no_done", done_cnt - d0, 0);
        tape_mode_en = 1'b1;
        tick();

        // cmd_valid held across two commands; code change during burst ignored
        wait_ready(ok);
        cmd_code = 6'd1; cmd_valid = 1'b1;
        tick();
        cmd_code = 6'd2;
        wait_done(limit, n);
        check("held_first_span", n, PER + QE + 1);
        check("held_first_pulses", pulses_sent, 1);
        tick();
        check("held_ready_after_done", cmd_ready, 1);
        check("held_no_overlap", step_out, 0);
        tick();
        check("held_second_start", step_out, 1);
        cmd_valid = 1'b0;
        wait_done(limit, n);
        check("held_second_span", n, 2 * PER + QE + 1);
        check("held_second_pulses", pulses_sent, 2);
        tick();

        // Reset mid-burst clears everything including pulses_sent
        wait_ready(ok);
        cmd_code = 6'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (2 * PER + P + 1) tick();
        reset = 1'b1;
        #1;
        check("rst_mid_step", step_out, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pulses", pulses_sent, 0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid_ready", cmd_ready, 1);

        // Randomized commands, aborts and held requests against the model
        for (int it = 0; it < 15; it++) begin
            wait_ready(ok);
            check("rand_ready", ok, 1);
            code = $urandom_range(0, 50);
            hold = $urandom_range(1, 3);
            cmd_code  = 6'(code);
            cmd_valid = 1'b1;
            repeat (hold) tick();
            cmd_valid = 1'b0;
            cmd_code  = 6'($urandom);
            if (code >= 1 && code <= 48 && $urandom_range(0, 3) == 0) begin
                abort_at = $urandom_range(0, code * PER);
                repeat (abort_at) tick();
                tape_mode_en = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                tape_mode_en = 1'b1;
            end
            tick();
        end
        wait_ready(ok);
        check("final_ready", ok, 1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete at cycle %0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
